alu_mult_sequencer: RTL and testbench
=====================================

Name: alu_mult_sequencer

Overview:
- Multicycle unsigned WIDTH x WIDTH shift-add multiplier with a 2*WIDTH-bit product.
- Owns no adder. It borrows the shared datapath ALU through the ALU-select mux, driving ALU opcode 3'b010 (add) and consuming the ALU's result and carryOut.
- Sits beside the multicycle control FSM. Control issues start, and waits for done while the sequencer holds the ALU (alu_sel=1).

Parameters:
- WIDTH, 32, operand width; must equal the ALU operand width.
- ALU_ADD_OP, 3'b010, ALU opcode for add with carry out.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- multiplicand  input  WIDTH  operand A; captured when start is accepted.
- multiplier  input  WIDTH  operand B; captured when start is accepted.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; product is valid from this cycle on.
- product  output  2*WIDTH  {HI,LO}; held until the next accepted start.
- alu_sel  output  1  high only in CALC; datapath mux routes alu_op*/alu_ctrl to the ALU.
- alu_op1  output  WIDTH  ALU operand1.
- alu_op2  output  WIDTH  ALU operand2.
- alu_ctrl  output  3  ALU operation code.
- alu_result  input  WIDTH  ALU resultOut.
- alu_carry  input  1  ALU carryOut.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, P (2*WIDTH product register)=0, mcand=0, cnt=0. Outputs: busy=0, done=0, product=0, alu_sel=0, alu_op1=0, alu_op2=0, alu_ctrl=3'b000.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 at edge N: mcand<=multiplicand, P<={WIDTH'b0, multiplier}, cnt<=0, state<=CALC.
  - start=0: remain in IDLE; P unchanged.
- CALC (ALU outputs are combinational from state and registers):
  - alu_sel=1, alu_ctrl=ALU_ADD_OP.
  - alu_op1=P[2*WIDTH-1:WIDTH].
  - alu_op2 = P[0] ? mcand : 0.
  - Each edge: P<={alu_carry, alu_result, P[WIDTH-1:1]}, cnt<=cnt+1.
  - When cnt==WIDTH-1 at the edge, state<=DONE.
  - Exactly WIDTH CALC cycles.
- DONE: done=1 for exactly one cycle, alu_sel=0, state<=IDLE next edge. start is ignored in DONE.
- Latency: start accepted at edge N, so CALC runs cycles N+1..N+WIDTH and done is high in cycle N+WIDTH+1. busy is high over the same span, N+1..N+WIDTH+1.
- product=P, a direct register output. It changes during CALC; consumers must read it only at or after done.
- Outside CALC: alu_op1=0, alu_op2=0, alu_ctrl=3'b000.
- start while busy: ignored. No queuing, no effect on the operation in flight.
- Back-to-back: start in the cycle after done is accepted normally. Throughput is one multiply per WIDTH+2 cycles.
- Operand inputs are don't-care except at the accepting edge.
- Reset mid-operation: immediate abort to the reset values above; no done pulse.
- Arithmetic: unsigned. The carry from the ALU add becomes bit 2*WIDTH-1 after the shift, so no overflow is possible.

Optional Feature:
- Macro: MULT_ZERO_SKIP_EN.
- Defined: if multiplicand==0 or multiplier==0 at the accepting edge, state<=DONE directly with P<=0. done is then high in cycle N+1, the ALU is never claimed (alu_sel stays 0), and busy is high for 1 cycle.
- Undefined: zero operands take the full WIDTH-cycle CALC path and yield product 0.

Test Plan:
- Basic: reset, then start with A=3, B=5 → alu_sel high 32 cycles, done in cycle N+33, product=64'h0000_0000_0000_000F.
- Full carry chain: A=B=32'hFFFF_FFFF → product=64'hFFFF_FFFE_0000_0001. Confirm alu_carry=1 is consumed during CALC.
- Boundary: A=32'h8000_0000, B=2 → product=64'h0000_0001_0000_0000. Then back-to-back start the cycle after done with A=7, B=6 → product=42.
- Busy and shortcut: start pulsed at cycles N+5 and N+33 (DONE) → ignored; product of the first op unchanged, single done pulse. Then A=0, B=9: with MULT_ZERO_SKIP_EN, done at N+1, alu_sel never high, product=0; without it, done at N+33, product=0.
- Reset abort: reset_n low at cycle N+10 → busy, done, alu_sel and product go 0 asynchronously, no done pulse. After release, a new start with A=2, B=2 → product=4.

Source files
------------

// File: rtl/alu_mult_sequencer_if.sv
// Bundle between the multiply sequencer, the control FSM that starts it, and the shared datapath ALU.
// The slave modport is the sequencer's view. The master modport is the view of control plus the ALU.
interface alu_mult_sequencer_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;
    logic                 alu_sel;
    logic [WIDTH-1:0]     alu_op1;
    logic [WIDTH-1:0]     alu_op2;
    logic [2:0]           alu_ctrl;
    logic [WIDTH-1:0]     alu_result;
    logic                 alu_carry;

    modport slave (
        input  start, multiplicand, multiplier, alu_result, alu_carry,
        output busy, done, product, alu_sel, alu_op1, alu_op2, alu_ctrl
    );

    modport master (
        output start, multiplicand, multiplier, alu_result, alu_carry,
        input  busy, done, product, alu_sel, alu_op1, alu_op2, alu_ctrl
    );
endinterface

// File: rtl/alu_mult_sequencer.sv
// Multicycle unsigned shift-add multiplier that borrows the shared datapath ALU for its additions.
// When MULT_ZERO_SKIP_EN is defined, a zero operand skips the CALC phase entirely.
module alu_mult_sequencer #(
    parameter int         WIDTH      = 32,
    parameter logic [2:0] ALU_ADD_OP = 3'b010,
    parameter int         CNT_W      = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    alu_mult_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state;
    state_t               next_state;
    logic [2*WIDTH-1:0]   p;
    logic [WIDTH-1:0]     mcand;
    logic [CNT_W-1:0]     cnt;
    logic                 last_iter;
    logic                 zero_op;

    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

`ifdef MULT_ZERO_SKIP_EN
    assign zero_op = (bus.multiplicand == '0) || (bus.multiplier == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = zero_op ? DONE : CALC;
            CALC:    if (last_iter) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The ALU carry becomes the new top bit, so the shift never loses a carry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p     <= '0;
            mcand <= '0;
            cnt   <= '0;
        end else if (state == IDLE && bus.start) begin
            mcand <= bus.multiplicand;
            cnt   <= '0;
            p     <= zero_op ? '0 : {{WIDTH{1'b0}}, bus.multiplier};
        end else if (state == CALC) begin
            p   <= {bus.alu_carry, bus.alu_result, p[WIDTH-1:1]};
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_comb begin
        bus.alu_sel  = 1'b0;
        bus.alu_ctrl = 3'b000;
        bus.alu_op1  = '0;
        bus.alu_op2  = '0;
        if (state == CALC) begin
            bus.alu_sel  = 1'b1;
            bus.alu_ctrl = ALU_ADD_OP;
            bus.alu_op1  = p[2*WIDTH-1:WIDTH];
            bus.alu_op2  = p[0] ? mcand : '0;
        end
    end

    assign bus.busy    = (state != IDLE);
    assign bus.done    = (state == DONE);
    assign bus.product = p;
endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Self-checking bench for alu_mult_sequencer: an ALU model answers the borrowed-ALU requests.
// A scoreboard queue holds the expected product, latency and ALU-claim length of each accepted start.
module tb_alu_mult_sequencer;
    localparam int WIDTH = 32;

`ifdef MULT_ZERO_SKIP_EN
    localparam int ZERO_LAT = 0;
`else
    localparam int ZERO_LAT = WIDTH;
`endif

    typedef struct {
        logic [63:0] prod;
        int          accept_edge;
        int          lat;
        int          sel;
    } exp_entry_t;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;
    int   cycle_count;
    int   alu_sel_run;
    logic carry_run;
    logic last_carry;
    logic [32:0] alu_sum;
    exp_entry_t scoreboard[$];

    alu_mult_sequencer_if #(.WIDTH(WIDTH)) bus ();

    alu_mult_sequencer #(
        .WIDTH(WIDTH),
        .ALU_ADD_OP(3'b010),
        .CNT_W(5)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave)
    );

    // The shared ALU adds only when it is claimed with the add opcode.
    always_comb begin
        alu_sum = '0;
        if (bus.alu_sel && bus.alu_ctrl == 3'b010)
            alu_sum = {1'b0, bus.alu_op1} + {1'b0, bus.alu_op2};
    end
    assign bus.alu_result = alu_sum[31:0];
    assign bus.alu_carry  = alu_sum[32];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_count <= cycle_count + 1;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks = checks + 1;
        if (observed !== expected) begin
            failures = failures + 1;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input int lat);
        exp_entry_t e;
        @(negedge clk);
        bus.start        = 1'b1;
        bus.multiplicand = a;
        bus.multiplier   = b;
        e.prod        = 64'(a) * 64'(b);
        e.accept_edge = cycle_count + 1;
        e.lat         = lat;
        e.sel         = (lat == 0) ? 0 : WIDTH;
        scoreboard.push_back(e);
        @(posedge clk);
        #1;
        bus.start        = 1'b0;
        bus.multiplicand = $urandom;
        bus.multiplier   = $urandom;
    endtask

    task automatic pulseStart(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start        = 1'b1;
        bus.multiplicand = a;
        bus.multiplier   = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        if (!seen) checkOutput("done_timeout", 64'd0, 64'd1);
    endtask

    // Every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset_n) begin
            alu_sel_run <= 0;
            carry_run   <= 1'b0;
        end else if (bus.done) begin
            if (scoreboard.size() == 0) begin
                checkOutput("spurious_done", 64'd1, 64'd0);
            end else begin
                exp_entry_t e;
                e = scoreboard.pop_front();
                checkOutput("product", bus.product, e.prod);
                checkOutput("latency", 64'(cycle_count - e.accept_edge), 64'(e.lat));
                checkOutput("alu_sel_cycles", 64'(alu_sel_run), 64'(e.sel));
            end
            last_carry  <= carry_run;
            alu_sel_run <= 0;
            carry_run   <= 1'b0;
        end else if (bus.alu_sel) begin
            alu_sel_run <= alu_sel_run + 1;
            carry_run   <= carry_run | bus.alu_carry;
        end
    end

    initial begin
        logic [63:0] held;
        checks           = 0;
        failures         = 0;
        cycle_count      = 0;
        last_carry       = 1'b0;
        reset_n          = 1'b0;
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        #1;
        checkOutput("rst_busy", 64'(bus.busy), 64'd0);
        checkOutput("rst_done", 64'(bus.done), 64'd0);
        checkOutput("rst_product", bus.product, 64'd0);
        checkOutput("rst_alu_sel", 64'(bus.alu_sel), 64'd0);
        checkOutput("rst_alu_op1", 64'(bus.alu_op1), 64'd0);
        checkOutput("rst_alu_op2", 64'(bus.alu_op2), 64'd0);
        checkOutput("rst_alu_ctrl", 64'(bus.alu_ctrl), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        applyStimulus(32'd3, 32'd5, WIDTH);
        waitDone(60);

        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, WIDTH);
        waitDone(60);
        @(posedge clk);
        #1;
        checkOutput("carry_consumed", 64'(last_carry), 64'd1);

        applyStimulus(32'h8000_0000, 32'd2, WIDTH);
        waitDone(60);
        applyStimulus(32'd7, 32'd6, WIDTH);
        waitDone(60);

        // Starts during CALC and during DONE must both be dropped.
        applyStimulus(32'h1234_5678, 32'h0000_9ABC, WIDTH);
        held = 64'h1234_5678 * 64'h0000_9ABC;
        repeat (3) @(negedge clk);
        pulseStart(32'd11, 32'd13);
        waitDone(60);
        bus.start        = 1'b1;
        bus.multiplicand = 32'd17;
        bus.multiplier   = 32'd19;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("ignored_busy", 64'(bus.busy), 64'd0);
        checkOutput("ignored_product", bus.product, held);

        applyStimulus(32'd0, 32'd9, ZERO_LAT);
        waitDone(60);

        applyStimulus(32'd12345, 32'd678, WIDTH);
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("abort_busy", 64'(bus.busy), 64'd0);
        checkOutput("abort_done", 64'(bus.done), 64'd0);
        checkOutput("abort_alu_sel", 64'(bus.alu_sel), 64'd0);
        checkOutput("abort_product", bus.product, 64'd0);
        scoreboard.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("abort_no_done", 64'(bus.done), 64'd0);

        applyStimulus(32'd2, 32'd2, WIDTH);
        waitDone(60);
        repeat (2) @(negedge clk);
        checkOutput("scoreboard_empty", 64'(scoreboard.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
